// File: rtl/shared_bus_arbiter_if.sv
// Request/grant bundle between the shared-bus arbiter and the leaf instances
// that take turns enabling their drivers onto one inout net.
interface shared_bus_arbiter_if #(
  parameter int NREQ = 3,
  parameter int IDW  = $clog2(NREQ)
);
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  owner;
  logic            busy;
  logic            preempt;

  // Arbiter side.
  modport slave (
    input  req,
    output grant,
    output owner,
    output busy,
    output preempt
  );

  // Requester side.
  modport master (
    output req,
    input  grant,
    input  owner,
    input  busy,
    input  preempt
  );
endinterface

// File: rtl/shared_bus_arbiter.sv
// Round-robin ownership arbiter for a shared inout bus: one grant at a time,
// bounded tenure, and dead turnaround cycles between successive owners.
module shared_bus_arbiter #(
  parameter int NREQ     = 3,
  parameter int MAX_HOLD = 16,
  parameter int TURN_CYC = 1,
  parameter int IDW      = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  shared_bus_arbiter_if.slave  bus
);

  localparam int HCW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(MAX_HOLD - 1);
  localparam logic [IDW-1:0] RR_INIT   = IDW'(NREQ - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_TURN  = 2'd2
  } state_t;

  // With no turnaround configured a tenure ends straight into arbitration.
  localparam state_t END_STATE = (TURN_CYC == 0) ? S_IDLE : S_TURN;

  state_t          r_state;
  logic [IDW-1:0]  r_owner;
  logic [HCW-1:0]  r_hold_cnt;
  logic [2:0]      r_turn_cnt;
  logic [IDW-1:0]  r_rr_last;
  logic            r_preempt;

  state_t          w_state_nxt;
  logic [IDW-1:0]  w_owner_nxt;
  logic [HCW-1:0]  w_hold_nxt;
  logic [2:0]      w_turn_nxt;
  logic [IDW-1:0]  w_rr_nxt;
  logic            w_preempt_nxt;

  logic [IDW-1:0]  w_sel;
  logic            w_sel_vld;
  logic [NREQ-1:0] w_owner_oh;
  logic            w_own_req;
  logic            w_others;

  // Round-robin pick: lowest requester above rr_last wins, else wrap to the
  // lowest requester at or below it. The second loop overrides the first.
  always_comb begin
    // NOTE: every signal gets a default before the branches so no latch is inferred.
    w_sel     = '0;
    w_sel_vld = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.req[i] && (IDW'(i) <= r_rr_last)) begin
        w_sel     = IDW'(i);
        w_sel_vld = 1'b1;
      end
    end
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.req[i] && (IDW'(i) > r_rr_last)) begin
        w_sel     = IDW'(i);
        w_sel_vld = 1'b1;
      end
    end
  end

  assign w_owner_oh = {{(NREQ-1){1'b0}}, 1'b1} << r_owner;
  assign w_own_req  = bus.req[r_owner];
  assign w_others   = |(bus.req & ~w_owner_oh);

  always_comb begin
    w_state_nxt   = r_state;
    w_owner_nxt   = r_owner;
    w_hold_nxt    = r_hold_cnt;
    w_turn_nxt    = r_turn_cnt;
    w_rr_nxt      = r_rr_last;
    w_preempt_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_sel_vld) begin
          w_state_nxt = S_GRANT;
          w_owner_nxt = w_sel;
          w_hold_nxt  = '0;
          w_rr_nxt    = w_sel;
        end
      end
      S_GRANT: begin
        // A release takes precedence over a simultaneous hold-limit hit.
        if (!w_own_req) begin
          w_state_nxt = END_STATE;
          w_owner_nxt = '0;
          w_hold_nxt  = '0;
          w_turn_nxt  = '0;
        end else if (r_hold_cnt == HOLD_LAST) begin
          w_hold_nxt = '0;
          if (w_others) begin
            w_state_nxt   = END_STATE;
            w_owner_nxt   = '0;
            w_turn_nxt    = '0;
            w_preempt_nxt = 1'b1;
          end
        end else begin
          w_hold_nxt = r_hold_cnt + 1'b1;
        end
      end
      S_TURN: begin
        if (int'(r_turn_cnt) >= TURN_CYC - 1) begin
          w_state_nxt = S_IDLE;
          w_turn_nxt  = '0;
        end else begin
          w_turn_nxt = r_turn_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_owner_nxt = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed above.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_owner    <= '0;
      r_hold_cnt <= '0;
      r_turn_cnt <= '0;
      r_rr_last  <= RR_INIT;
      r_preempt  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_turn_cnt <= w_turn_nxt;
      r_rr_last  <= w_rr_nxt;
      r_preempt  <= w_preempt_nxt;
    end
  end

  // Outputs decode registered state only, so grant falls as soon as reset rises.
  always_comb begin
    bus.grant   = (r_state == S_GRANT) ? w_owner_oh : '0;
    bus.owner   = (r_state == S_GRANT) ? r_owner : '0;
    bus.busy    = (r_state == S_GRANT);
    bus.preempt = r_preempt;
  end

endmodule

// File: tb/tb_shared_bus_arbiter.sv
// Directed and randomized bench for shared_bus_arbiter, compared every cycle
// against a tenure-level reference model.
module tb_shared_bus_arbiter;

  localparam int NREQ     = 3;
  localparam int MAX_HOLD = 4;
  localparam int TURN_CYC = 1;
  localparam int IDW      = $clog2(NREQ);
  localparam int FAIR_MAX = (NREQ - 1) * (MAX_HOLD + TURN_CYC + 1) + 2;

  logic clk;
  logic reset;

  shared_bus_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  shared_bus_arbiter #(
    .NREQ    (NREQ),
    .MAX_HOLD(MAX_HOLD),
    .TURN_CYC(TURN_CYC),
    .IDW     (IDW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the bus, how long they have held it, how many
  // dead cycles remain before the next arbitration, and the last winner.
  int m_own;
  int m_ten;
  int m_wait;
  int m_last;
  bit m_pre;

  int  cyc;
  bit  fair_en;
  int  wait_cnt [NREQ];
  logic [NREQ-1:0] glog [0:31];
  logic [IDW-1:0]  olog [0:31];
  logic            plog [0:31];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_own  = -1;
    m_ten  = 0;
    m_wait = 0;
    m_last = NREQ - 1;
    m_pre  = 1'b0;
    for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
  endtask

  task automatic model_step(input logic [NREQ-1:0] r);
    logic [NREQ-1:0] oh;
    bit found;
    m_pre = 1'b0;
    if (m_own >= 0) begin
      oh = NREQ'(1) << m_own;
      if ((r & oh) == '0) begin
        m_own  = -1;
        m_wait = TURN_CYC;
      end else if ((m_ten % MAX_HOLD) == 0 && (r & ~oh) != '0) begin
        m_own  = -1;
        m_wait = TURN_CYC;
        m_pre  = 1'b1;
      end else begin
        m_ten++;
      end
    end else if (m_wait > 0) begin
      m_wait--;
    end else if (r != '0) begin
      found = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
        int c;
        c = (m_last + k) % NREQ;
        if (!found && r[c]) begin
          found  = 1'b1;
          m_own  = c;
          m_ten  = 1;
          m_last = c;
        end
      end
    end
  endtask

  // One clock: model advances on the pre-edge request, DUT sampled 1 ns later.
  task automatic tick();
    logic [NREQ-1:0] r;
    logic [NREQ-1:0] exp_grant;
    r = bus.req;
    @(posedge clk);
    model_step(r);
    #1;
    exp_grant = (m_own >= 0) ? (NREQ'(1) << m_own) : '0;
    check("grant",   32'(bus.grant), 32'(exp_grant));
    check("owner",   32'(bus.owner), (m_own >= 0) ? 32'(m_own) : 32'd0);
    check("busy",    32'(bus.busy),  (m_own >= 0) ? 32'd1 : 32'd0);
    check("preempt", 32'(bus.preempt), 32'(m_pre));
    check("onehot0", 32'($onehot0(bus.grant)), 32'd1);
    if (bus.preempt === 1'b1) check("preempt_nogrant", 32'(bus.grant), 32'd0);
    if (fair_en) begin
      for (int i = 0; i < NREQ; i++) begin
        if (r[i] && !bus.grant[i]) wait_cnt[i]++;
        else wait_cnt[i] = 0;
        check("fair_bound", 32'(wait_cnt[i] <= FAIR_MAX), 32'd1);
      end
    end
    cyc++;
    if (cyc < 32) begin
      glog[cyc] = bus.grant;
      olog[cyc] = bus.owner;
      plog[cyc] = bus.preempt;
    end
  endtask

  task automatic do_reset(input logic [NREQ-1:0] r);
    bus.req = r;
    reset   = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    cyc = 0;
    glog[0] = '0;
    plog[0] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_start;
    int n_pre;
    int n_cnt;
    int order [4];
    reset   = 1'b0;
    bus.req = '0;
    fair_en = 1'b0;
    cyc     = 0;
    model_reset();

    // 1: single requester, release after a short tenure.
    do_reset('0);
    check("rst_grant",   32'(bus.grant),   32'd0);
    check("rst_owner",   32'(bus.owner),   32'd0);
    check("rst_busy",    32'(bus.busy),    32'd0);
    check("rst_preempt", 32'(bus.preempt), 32'd0);
    bus.req = 3'b001;
    repeat (5) tick();
    bus.req = 3'b000;
    repeat (4) tick();
    check("t1_c1_grant", 32'(glog[1]), 32'b001);
    check("t1_c6_grant", 32'(glog[6]), 32'b000);
    check("t1_c9_grant", 32'(glog[9]), 32'b000);

    // 2: release hands over after TURN plus the IDLE evaluation cycle.
    do_reset('0);
    bus.req = 3'b011;
    repeat (3) tick();
    bus.req = 3'b010;
    repeat (4) tick();
    check("t2_c3_grant", 32'(glog[3]), 32'b001);
    check("t2_c4_grant", 32'(glog[4]), 32'b000);
    check("t2_c5_grant", 32'(glog[5]), 32'b000);
    check("t2_c6_grant", 32'(glog[6]), 32'b010);
    check("t2_c6_owner", 32'(olog[6]), 32'd1);

    // 3: hold limit preemption between two persistent requesters.
    do_reset('0);
    bus.req = 3'b011;
    repeat (13) tick();
    check("t3_c4_grant",   32'(glog[4]),  32'b001);
    check("t3_c5_preempt", 32'(plog[5]),  32'd1);
    check("t3_c5_grant",   32'(glog[5]),  32'b000);
    check("t3_c6_grant",   32'(glog[6]),  32'b000);
    check("t3_c7_grant",   32'(glog[7]),  32'b010);
    check("t3_c10_grant",  32'(glog[10]), 32'b010);
    check("t3_c11_preempt",32'(plog[11]), 32'd1);
    check("t3_c13_grant",  32'(glog[13]), 32'b001);

    // 4: a lone requester keeps the bus past the hold limit.
    do_reset('0);
    bus.req = 3'b100;
    repeat (20) tick();
    n_pre = 0;
    n_cnt = 0;
    for (int c = 1; c <= 20; c++) begin
      if (plog[c]) n_pre++;
      if (glog[c] == 3'b100 && olog[c] == 2'd2) n_cnt++;
    end
    check("t4_no_preempt", 32'(n_pre), 32'd0);
    check("t4_held_cycles", 32'(n_cnt), 32'd20);

    // 5: all three requesting rotate 0,1,2,0 with one preempt per handover.
    do_reset('0);
    bus.req = 3'b111;
    repeat (20) tick();
    n_start = 0;
    n_pre   = 0;
    for (int c = 1; c <= 20; c++) begin
      if (plog[c]) n_pre++;
      if (glog[c] != '0 && glog[c-1] == '0) begin
        if (n_start < 4) order[n_start] = int'(olog[c]);
        n_start++;
      end
    end
    check("t5_tenures", 32'(n_start), 32'd4);
    check("t5_preempts", 32'(n_pre), 32'd3);
    if (n_start >= 4) begin
      check("t5_order0", 32'(order[0]), 32'd0);
      check("t5_order1", 32'(order[1]), 32'd1);
      check("t5_order2", 32'(order[2]), 32'd2);
      check("t5_order3", 32'(order[3]), 32'd0);
    end

    // 6: asynchronous reset mid-tenure drops the grant at once.
    do_reset('0);
    bus.req = 3'b010;
    repeat (3) tick();
    check("t6_before_rst", 32'(bus.grant), 32'b010);
    #4 reset = 1'b1;
    model_reset();
    #1;
    check("t6_async_grant", 32'(bus.grant), 32'd0);
    check("t6_async_busy",  32'(bus.busy),  32'd0);
    @(posedge clk);
    #3 reset = 1'b0;
    cyc = 0;
    tick();
    check("t6_regrant", 32'(glog[1]), 32'b010);
    reset = 1'b1;
    model_reset();
    bus.req = 3'b011;
    @(posedge clk);
    #3 reset = 1'b0;
    cyc = 0;
    tick();
    check("t6_req0_first", 32'(glog[1]), 32'b001);

    // Random phase with fairness bound on continuously waiting requesters.
    do_reset('0);
    fair_en = 1'b1;
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 5) == 0) bus.req = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      tick();
    end
    fair_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
